// File: rtl/interface_input_if.sv
// interface_input_if: bus-write and core-handshake bundle for the CORDIC input stage.
//   wr_en/wr_addr/wr_data : 32-bit register writes (0=XY, 1=DEG, 2=CTRL, 3=reserved)
//   status_out            : pending / sticky overflow / launch count
//   x_in/y_in/degree_in/flip_in/arctan_en_in/valid_in : job presented to the core
//   ready_in              : core accepts the presented job this cycle
// slave  = the input stage itself; master = the bus/core environment around it.
interface interface_input_if #(
  parameter int INPUT_WIDTH     = 16,
  parameter int FLIP_FLAG_WIDTH = 1
);
  logic                       wr_en;
  logic [1:0]                 wr_addr;
  logic [31:0]                wr_data;
  logic                       ready_in;
  logic [INPUT_WIDTH-1:0]     x_in;
  logic [INPUT_WIDTH-1:0]     y_in;
  logic [INPUT_WIDTH-1:0]     degree_in;
  logic [FLIP_FLAG_WIDTH-1:0] flip_in;
  logic                       arctan_en_in;
  logic                       valid_in;
  logic [31:0]                status_out;

  modport master (
    output wr_en, wr_addr, wr_data, ready_in,
    input  x_in, y_in, degree_in, flip_in, arctan_en_in, valid_in, status_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, ready_in,
    output x_in, y_in, degree_in, flip_in, arctan_en_in, valid_in, status_out
  );
endinterface

// File: rtl/interface_input.sv
// interface_input: bus-side input stage of the CORDIC accelerator.
// Captures operand/control writes into staging registers, snapshots a launched
// job into a one-entry holding register (with arctan left-half-plane pre-flip)
// and presents it to the core with valid/ready. Reports status to the bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : interface_input_if slave (bus writes, status, core handshake)
module interface_input #(
  parameter int INPUT_WIDTH      = 16,
  parameter int INPUT_INT_WIDTH  = 7,
  parameter int INPUT_FRAC_WIDTH = 8,
  parameter int FLIP_FLAG_WIDTH  = 1,
  parameter int COUNT_WIDTH      = 8
) (
  input logic               clk,
  input logic               rst,
  interface_input_if.slave  bus
);

  // Operand format is sign + integer + fraction; catch mismatched overrides early.
  if (1 + INPUT_INT_WIDTH + INPUT_FRAC_WIDTH != INPUT_WIDTH) begin : g_bad_fmt
    $error("interface_input: operand format does not add up to INPUT_WIDTH");
  end

  localparam logic [1:0] ADDR_XY   = 2'd0;
  localparam logic [1:0] ADDR_DEG  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  localparam logic [INPUT_WIDTH-1:0] S_MIN = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [INPUT_WIDTH-1:0] S_MAX = {1'b0, {(INPUT_WIDTH-1){1'b1}}};

  typedef struct packed {
    logic [INPUT_WIDTH-1:0]     x;
    logic [INPUT_WIDTH-1:0]     y;
    logic [INPUT_WIDTH-1:0]     deg;
    logic [FLIP_FLAG_WIDTH-1:0] flip;
    logic                       mode;
  } job_t;

  logic [INPUT_WIDTH-1:0] x_stage, y_stage, deg_stage;
  logic [0:0]             state;
  logic                   overflow;
  logic [COUNT_WIDTH-1:0] count;
  job_t                   job, job_nxt;

  logic ctrl_wr, launch, xfer, accept, reject, clr_ovf;

  assign ctrl_wr = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  assign launch  = ctrl_wr && bus.wr_data[1];
  assign clr_ovf = ctrl_wr && bus.wr_data[2];
  assign xfer    = (state == FULL) && bus.ready_in;
  // The slot is free either because nothing is held or because it leaves this edge.
  assign accept  = launch && ((state == IDLE) || bus.ready_in);
  assign reject  = launch && (state == FULL) && !bus.ready_in;

  // Snapshot from staging as of this cycle's start; mode rides on the launch write.
  always_comb begin
    job_nxt      = '0;
    job_nxt.y    = y_stage;
    job_nxt.deg  = deg_stage;
    job_nxt.mode = bus.wr_data[0];
    job_nxt.x    = x_stage;
    if (bus.wr_data[0] && x_stage[INPUT_WIDTH-1]) begin
      // Pre-flip into the right half plane; most-negative value saturates.
      job_nxt.x    = (x_stage == S_MIN) ? S_MAX : -x_stage;
      job_nxt.flip = FLIP_FLAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_stage   <= '0;
      y_stage   <= '0;
      deg_stage <= '0;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_XY: begin
          x_stage <= bus.wr_data[INPUT_WIDTH-1:0];
          y_stage <= bus.wr_data[16 +: INPUT_WIDTH];
        end
        ADDR_DEG: deg_stage <= bus.wr_data[INPUT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      job      <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      if (accept) begin
        state <= FULL;
        job   <= job_nxt;
        count <= count + 1'b1;
      end else if (xfer) begin
        state <= IDLE;
      end
      // A rejected launch outranks a clear carried by the same write.
      if (reject)       overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_comb begin
    bus.status_out                  = '0;
    bus.status_out[0]               = (state == FULL);
    bus.status_out[1]               = overflow;
    bus.status_out[8 +: COUNT_WIDTH] = count;
  end

  assign bus.x_in         = job.x;
  assign bus.y_in         = job.y;
  assign bus.degree_in    = job.deg;
  assign bus.flip_in      = job.flip;
  assign bus.arctan_en_in = job.mode;
  assign bus.valid_in     = (state == FULL);

endmodule

// File: tb/tb_interface_input.sv
// Directed bench for interface_input: inputs driven on the falling edge,
// outputs sampled on the falling edge after each rising edge.
module tb_interface_input;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  interface_input_if #(.INPUT_WIDTH(16), .FLIP_FLAG_WIDTH(1)) bus ();

  interface_input #(
    .INPUT_WIDTH(16), .INPUT_INT_WIDTH(7), .INPUT_FRAC_WIDTH(8),
    .FLIP_FLAG_WIDTH(1), .COUNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Called at a falling edge; the write is consumed by the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.ready_in = 1'b0;
    @(negedge clk);
    do_reset();
    tests++; if (bus.valid_in !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.valid_in); end
    tests++; if (bus.status_out !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 00000000", bus.status_out); end
    tests++; if ({bus.x_in, bus.y_in, bus.degree_in, bus.flip_in, bus.arctan_en_in} !== 50'h0) begin
      fails++; $display("FAIL reset_outputs got x=%h y=%h d=%h f=%b m=%b exp all 0",
                        bus.x_in, bus.y_in, bus.degree_in, bus.flip_in, bus.arctan_en_in);
    end
  endtask

  task automatic test_basic();
    bus.ready_in = 1'b1;
    wr(2'd0, 32'h0040_0100);
    wr(2'd1, 32'hABCD_1680);
    wr(2'd3, 32'h0000_0002);  // reserved address: no launch
    tests++; if (bus.valid_in !== 1'b0) begin fails++; $display("FAIL basic_reserved got valid=%b exp 0", bus.valid_in); end
    wr(2'd2, 32'h0000_0002);
    tests++; if (bus.valid_in !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", bus.valid_in); end
    tests++; if (bus.x_in !== 16'h0100) begin fails++; $display("FAIL basic_x got %h exp 0100", bus.x_in); end
    tests++; if (bus.y_in !== 16'h0040) begin fails++; $display("FAIL basic_y got %h exp 0040", bus.y_in); end
    tests++; if (bus.degree_in !== 16'h1680) begin fails++; $display("FAIL basic_deg got %h exp 1680", bus.degree_in); end
    tests++; if ({bus.flip_in, bus.arctan_en_in} !== 2'b00) begin fails++; $display("FAIL basic_flip_mode got %b%b exp 00", bus.flip_in, bus.arctan_en_in); end
    tests++; if (bus.status_out !== 32'h0000_0101) begin fails++; $display("FAIL basic_status got %h exp 00000101", bus.status_out); end
    @(negedge clk);
    tests++; if (bus.valid_in !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got valid=%b exp 0", bus.valid_in); end
    tests++; if (bus.status_out !== 32'h0000_0100) begin fails++; $display("FAIL basic_status_idle got %h exp 00000100", bus.status_out); end
  endtask

  task automatic test_arctan();
    bus.ready_in = 1'b1;
    wr(2'd0, 32'h0080_FF00);
    wr(2'd2, 32'h0000_0003);
    tests++; if (bus.x_in !== 16'h0100) begin fails++; $display("FAIL arctan_x got %h exp 0100", bus.x_in); end
    tests++; if (bus.y_in !== 16'h0080) begin fails++; $display("FAIL arctan_y got %h exp 0080", bus.y_in); end
    tests++; if ({bus.flip_in, bus.arctan_en_in} !== 2'b11) begin fails++; $display("FAIL arctan_flip_mode got %b%b exp 11", bus.flip_in, bus.arctan_en_in); end
    tests++; if (bus.degree_in !== 16'h1680) begin fails++; $display("FAIL arctan_deg got %h exp 1680", bus.degree_in); end
    tests++; if (bus.status_out !== 32'h0000_0201) begin fails++; $display("FAIL arctan_status got %h exp 00000201", bus.status_out); end
    wr(2'd0, 32'h0000_8000);  // transfer of previous job happens on this edge
    wr(2'd2, 32'h0000_0003);
    tests++; if (bus.x_in !== 16'h7FFF) begin fails++; $display("FAIL arctan_sat_x got %h exp 7fff", bus.x_in); end
    tests++; if (bus.flip_in !== 1'b1) begin fails++; $display("FAIL arctan_sat_flip got %b exp 1", bus.flip_in); end
    tests++; if (bus.y_in !== 16'h0000) begin fails++; $display("FAIL arctan_sat_y got %h exp 0000", bus.y_in); end
    wr(2'd0, 32'h0000_0010);
    wr(2'd2, 32'h0000_0003);  // positive x in arctan mode: no flip
    tests++; if ({bus.x_in, bus.flip_in, bus.arctan_en_in} !== {16'h0010, 2'b01}) begin
      fails++; $display("FAIL arctan_pos got x=%h f=%b m=%b exp x=0010 f=0 m=1", bus.x_in, bus.flip_in, bus.arctan_en_in);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.ready_in = 1'b0;
    do_reset();
    wr(2'd0, 32'h0003_0005);
    wr(2'd2, 32'h0000_0002);
    wr(2'd0, 32'h1111_2222);
    tests++; if ({bus.x_in, bus.y_in} !== {16'h0005, 16'h0003}) begin fails++; $display("FAIL bp_hold got x=%h y=%h exp x=0005 y=0003", bus.x_in, bus.y_in); end
    tests++; if (bus.valid_in !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", bus.valid_in); end
    wr(2'd2, 32'h0000_0002);
    tests++; if (bus.status_out !== 32'h0000_0103) begin fails++; $display("FAIL bp_reject got %h exp 00000103", bus.status_out); end
    tests++; if (bus.x_in !== 16'h0005) begin fails++; $display("FAIL bp_reject_x got %h exp 0005", bus.x_in); end
    wr(2'd2, 32'h0000_0006);  // clear and rejected launch together: set wins
    tests++; if (bus.status_out !== 32'h0000_0103) begin fails++; $display("FAIL bp_set_wins got %h exp 00000103", bus.status_out); end
    wr(2'd2, 32'h0000_0004);
    tests++; if (bus.status_out !== 32'h0000_0101) begin fails++; $display("FAIL bp_clear got %h exp 00000101", bus.status_out); end
  endtask

  // Continues from backpressure: job x=5 held, staging holds 0x1111_2222.
  task automatic test_back_to_back();
    bus.ready_in = 1'b1;
    wr(2'd2, 32'h0000_0002);
    tests++; if (bus.valid_in !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b exp 1", bus.valid_in); end
    tests++; if ({bus.x_in, bus.y_in} !== {16'h2222, 16'h1111}) begin fails++; $display("FAIL b2b_data got x=%h y=%h exp x=2222 y=1111", bus.x_in, bus.y_in); end
    tests++; if (bus.status_out !== 32'h0000_0201) begin fails++; $display("FAIL b2b_status got %h exp 00000201", bus.status_out); end
    @(negedge clk);
    tests++; if (bus.status_out !== 32'h0000_0200) begin fails++; $display("FAIL b2b_drain got %h exp 00000200", bus.status_out); end
  endtask

  task automatic test_wrap();
    bus.ready_in = 1'b1;
    do_reset();
    for (int i = 0; i < 255; i++) wr(2'd2, 32'h0000_0002);
    tests++; if (bus.status_out !== 32'h0000_FF01) begin fails++; $display("FAIL wrap_255 got %h exp 0000ff01", bus.status_out); end
    wr(2'd2, 32'h0000_0002);
    tests++; if (bus.status_out !== 32'h0000_0001) begin fails++; $display("FAIL wrap_256 got %h exp 00000001", bus.status_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.ready_in = 1'b0;
    wr(2'd0, 32'h0007_0009);
    wr(2'd2, 32'h0000_0002);
    tests++; if (bus.valid_in !== 1'b1) begin fails++; $display("FAIL mid_pre got valid=%b exp 1", bus.valid_in); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (bus.valid_in !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", bus.valid_in); end
    tests++; if (bus.status_out !== 32'h0) begin fails++; $display("FAIL mid_status got %h exp 00000000", bus.status_out); end
    tests++; if (bus.x_in !== 16'h0) begin fails++; $display("FAIL mid_x got %h exp 0000", bus.x_in); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arctan();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/interface_input.md
# interface_input

Bus-side input stage for the CORDIC accelerator. It captures 32-bit bus writes of operands and control, snapshots a launched job into a one-entry holding register, and presents it to the CORDIC core with a valid/ready handshake. It also applies the left-half-plane pre-flip for arctan jobs and reports status back to the bus. The output interface later uses the flip flag to undo that pre-flip.

## Interface
- INPUT_WIDTH, 16, operand width (signed fixed point)
- INPUT_INT_WIDTH, 7, integer bits of operands
- INPUT_FRAC_WIDTH, 8, fractional bits of operands
- FLIP_FLAG_WIDTH, 1, width of flip flag
- COUNT_WIDTH, 8, width of launch counter

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  bus write strobe, one write per cycle
- wr_addr  in  2  register select: 0 = XY, 1 = DEG, 2 = CTRL, 3 = reserved (write ignored)
- wr_data  in  32  write data
- ready_in  in  1  CORDIC core can accept a job this cycle
- x_in  out  INPUT_WIDTH  launched x (after pre-flip)
- y_in  out  INPUT_WIDTH  launched y
- degree_in  out  INPUT_WIDTH  launched angle
- flip_in  out  FLIP_FLAG_WIDTH  pre-flip applied to this job
- arctan_en_in  out  1  job mode: 1 = vectoring/arctan, 0 = rotation
- valid_in  out  1  job presented to core
- status_out  out  32  bit0 pending, bit1 overflow (sticky), bits[COUNT_WIDTH+7:8] launch count, other bits 0

## Operation
- Staging registers are written only by bus writes; they never drive the core directly:
  - XY: x_stage = wr_data[15:0], y_stage = wr_data[31:16]. The packing mirrors the output word.
  - DEG: deg_stage = wr_data[15:0]; bits [31:16] are ignored.
  - CTRL: bit0 = mode, bit1 = launch, bit2 = clear overflow.
- Staging writes are allowed at any time. They never disturb a pending or presented job.
- Launch: a CTRL write with bit1 = 1.
  - The launch is accepted when pending = 0, or when valid_in && ready_in in the same cycle (slot frees).
  - On accept, the outputs snapshot from staging and pending is set.
  - An accepted launch increments the launch count, which wraps modulo 2^COUNT_WIDTH.
- Rejected launch (pending = 1 and no transfer this cycle): snapshot unchanged, overflow set, count unchanged.
- Pre-flip, computed at snapshot:
  - If mode = 1 and x_stage < 0: x_in = -x_stage and flip_in = 1.
  - Negation saturates: -32768 becomes 32767.
  - Otherwise x_in = x_stage and flip_in = 0.
  - y_in and degree_in are copied unchanged in all modes.
- Overflow clear: a CTRL write with bit2 = 1 clears overflow. If the same write also gets a rejected launch, the set wins and overflow stays 1.
- State machine, two states:
  - IDLE (pending = 0) → FULL on an accepted launch.
  - FULL → IDLE on valid_in && ready_in with no simultaneous launch.
  - FULL stays FULL when a transfer and an accepted launch coincide; the new snapshot is loaded.
- valid_in = pending. The outputs hold stable while valid_in = 1 and ready_in = 0.

## Timing
- Reset values: all staging registers 0; x_in, y_in, degree_in, flip_in, arctan_en_in = 0; valid_in = 0; status_out = 0.
- A launch write in cycle N makes valid_in = 1 with new data from cycle N+1 (1-cycle latency).
- A transfer occurs on the rising edge where valid_in && ready_in. valid_in deasserts in the next cycle unless a launch was accepted in the transfer cycle.
- A staging write and a launch in the same cycle are impossible: there is only one write port. The launch uses staging contents as of that cycle's start.
- Reset asserted mid-job drops valid_in in the next cycle. The job is lost and the count returns to 0.
- status_out is registered and reflects state after the previous edge.

## Test plan
- Reset, then XY = 0x0040_0100, DEG = 0x0000_1680, CTRL = 0x2, with ready_in = 1:
  - valid_in is high for exactly 1 cycle.
  - x_in = 0x0100, y_in = 0x0040, degree_in = 0x1680, flip_in = 0, arctan_en_in = 0.
  - status count = 1.
- Arctan pre-flip:
  - XY = 0x0080_FF00, CTRL = 0x3 → x_in = 0x0100, flip_in = 1, y_in = 0x0080.
  - XY = 0x0000_8000 → x_in = 0x7FFF.
- Backpressure with ready_in = 0:
  - Launch, then rewrite XY = 0x1111_2222 → x_in and y_in are unchanged and valid_in holds.
  - A second launch sets overflow and leaves count = 1.
  - CTRL = 0x4 then clears overflow.
- With ready_in = 1 while pending, launch a second job in the same cycle as the transfer:
  - valid_in stays high and carries the new snapshot.
  - No overflow is set and count increments to 2.
- Issue 256 accepted launches → count wraps to 0.
- Assert rst while valid_in = 1 → next cycle valid_in = 0 and status_out = 0.
